// File: rtl/mmio_hub.sv
// mmio_hub: memory-mapped I/O hub between the OTTER MCU I/O bus and board
// peripherals.
//
// Address map: slot k lives at BASE + k*STRIDE, and only exact matches decode.
//   slots 0..N_IN-1           input ports (read-only, unregistered)
//   slots N_IN..N_IN+N_OUT-1  output registers (each write pulses OUT_WSTB)
//   slot  P=N_IN+N_OUT        IRQ_PEND  (read; write-1-to-clear)
//   slot  P+1                 IRQ_MASK  (read/write, N_IRQ bits stored)
//   slot  P+2                 IRQ_CAUSE (lowest pending&masked index, or all ones)
//
// Ports:
//   CLK, RESET_N          clock; asynchronous active-low reset
//   IOBUS_ADDR/OUT/WR     MCU address, write data, write enable
//   IOBUS_IN              combinational read data
//   IN_DATA               N_IN packed 32-bit input ports
//   OUT_DATA, OUT_WSTB    N_OUT packed 32-bit output registers, write strobes
//   IRQ_SRC, INTR         asynchronous interrupt levels, registered request
//
// Build option: define MMIO_HUB_READBACK_EN to make output slots readable;
// without it output slots read as zero and no readback mux is built.

// One interrupt lane: two-flop synchroniser, a third flop for rising-edge
// detection, and the pending bit.
module mmio_hub_irq_lane (
  input  logic gclk,
  input  logic grst_n,
  input  logic src_i,
  input  logic clr_i,
  output logic pend_o
);
  // sync_q[1:0] synchronise, sync_q[2] is the previous synchronised level
  logic [2:0] sync_q;
  logic       pend_q, pend_d, rise;

  assign rise   = sync_q[1] & ~sync_q[2];
  // A new edge overrides a simultaneous clear
  assign pend_d = rise | (pend_q & ~clr_i);
  assign pend_o = pend_q;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      sync_q <= '0;
      pend_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], src_i};
      pend_q <= pend_d;
    end
  end
endmodule

module mmio_hub #(
  parameter int          N_IN   = 4,
  parameter int          N_OUT  = 4,
  parameter int          N_IRQ  = 4,
  parameter logic [31:0] BASE   = 32'h11000000,
  parameter logic [31:0] STRIDE = 32'h00040000
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [31:0]           IOBUS_ADDR,
  input  logic [31:0]           IOBUS_OUT,
  input  logic                  IOBUS_WR,
  output logic [31:0]           IOBUS_IN,
  input  logic [32*N_IN-1:0]    IN_DATA,
  output logic [32*N_OUT-1:0]   OUT_DATA,
  output logic [N_OUT-1:0]      OUT_WSTB,
  input  logic [N_IRQ-1:0]      IRQ_SRC,
  output logic                  INTR
);
  localparam int P      = N_IN + N_OUT;
  localparam int N_SLOT = P + 3;

  logic [N_SLOT-1:0]           hit;
  logic [N_OUT-1:0][31:0]      out_q;
  logic [N_OUT-1:0]            wstb_q, out_we;
  logic [N_IRQ-1:0]            mask_q, pend, pend_clr, act;
  logic                        mask_we, intr_q;
  logic [31:0]                 cause, rdata;

  for (genvar k = 0; k < N_SLOT; k++) begin : g_dec
    assign hit[k] = (IOBUS_ADDR == BASE + STRIDE * 32'(k));
  end

  assign out_we   = {N_OUT{IOBUS_WR}} & hit[N_IN +: N_OUT];
  assign mask_we  = IOBUS_WR & hit[P+1];
  assign pend_clr = (IOBUS_WR & hit[P]) ? IOBUS_OUT[N_IRQ-1:0] : '0;
  assign act      = pend & mask_q;

  mmio_hub_irq_lane u_lane [N_IRQ-1:0] (
    .gclk   (CLK),
    .grst_n (RESET_N),
    .src_i  (IRQ_SRC),
    .clr_i  (pend_clr),
    .pend_o (pend)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      out_q  <= '0;
      wstb_q <= '0;
      mask_q <= '0;
      intr_q <= 1'b0;
    end else begin
      wstb_q <= out_we;
      for (int j = 0; j < N_OUT; j++)
        if (out_we[j]) out_q[j] <= IOBUS_OUT;
      if (mask_we) mask_q <= IOBUS_OUT[N_IRQ-1:0];
      intr_q <= |act;
    end
  end

  // Lowest active index wins, so scan from the top down
  always_comb begin
    cause = '1;
    for (int i = N_IRQ-1; i >= 0; i--)
      if (act[i]) cause = 32'(i);
  end

  always_comb begin
    rdata = '0;
    for (int k = 0; k < N_IN; k++)
      if (hit[k]) rdata = IN_DATA[32*k +: 32];
`ifdef MMIO_HUB_READBACK_EN
    for (int j = 0; j < N_OUT; j++)
      if (hit[N_IN+j]) rdata = out_q[j];
`endif
    if (hit[P])   rdata = 32'(pend);
    if (hit[P+1]) rdata = 32'(mask_q);
    if (hit[P+2]) rdata = cause;
  end

  assign IOBUS_IN = rdata;
  assign OUT_DATA = out_q;
  assign OUT_WSTB = wstb_q;
  assign INTR     = intr_q;
endmodule

// File: tb/tb_mmio_hub.sv
module tb_mmio_hub;
  localparam int          N_IN   = 4;
  localparam int          N_OUT  = 4;
  localparam int          N_IRQ  = 4;
  localparam logic [31:0] BASE   = 32'h11000000;
  localparam logic [31:0] STRIDE = 32'h00040000;
  localparam int          P      = N_IN + N_OUT;
`ifdef MMIO_HUB_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic                 CLK = 1'b0;
  logic                 RESET_N = 1'b0;
  logic [31:0]          IOBUS_ADDR = '0, IOBUS_OUT = '0, IOBUS_IN;
  logic                 IOBUS_WR = 1'b0;
  logic [32*N_IN-1:0]   IN_DATA = '0;
  logic [32*N_OUT-1:0]  OUT_DATA;
  logic [N_OUT-1:0]     OUT_WSTB;
  logic [N_IRQ-1:0]     IRQ_SRC = '0;
  logic                 INTR;

  mmio_hub #(.N_IN(N_IN), .N_OUT(N_OUT), .N_IRQ(N_IRQ), .BASE(BASE), .STRIDE(STRIDE)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT),
    .IOBUS_WR(IOBUS_WR), .IOBUS_IN(IOBUS_IN), .IN_DATA(IN_DATA), .OUT_DATA(OUT_DATA),
    .OUT_WSTB(OUT_WSTB), .IRQ_SRC(IRQ_SRC), .INTR(INTR)
  );

  always #5 CLK = ~CLK;

  int n_pass = 0, n_total = 0;
  logic [31:0] m_out [N_OUT];   // model of the output registers
  logic [31:0] m_in  [N_IN];    // what the bench drives on the input ports

  function automatic logic [31:0] sa(input int k);
    return BASE + STRIDE * 32'(k);
  endfunction

  function automatic logic [31:0] exp_cause(input logic [N_IRQ-1:0] v);
    for (int i = 0; i < N_IRQ; i++) if (v[i]) return 32'(i);
    return 32'hFFFFFFFF;
  endfunction

  function automatic logic [32*N_OUT-1:0] exp_out();
    logic [32*N_OUT-1:0] e;
    for (int j = 0; j < N_OUT; j++) e[32*j +: 32] = m_out[j];
    return e;
  endfunction

  task automatic tick(); @(posedge CLK); #1; endtask

  task automatic rd(input int k, output logic [31:0] d);
    IOBUS_ADDR = sa(k); #1; d = IOBUS_IN;
  endtask

  task automatic wr(input int k, input logic [31:0] d);
    IOBUS_ADDR = sa(k); IOBUS_OUT = d; IOBUS_WR = 1'b1;
    tick();
    IOBUS_WR = 1'b0; IOBUS_ADDR = '0;
  endtask

  task automatic drive_in();
    for (int k = 0; k < N_IN; k++) IN_DATA[32*k +: 32] = m_in[k];
  endtask

  task automatic test_reset();
    logic [31:0] d;
    RESET_N = 1'b0;
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < N_IN; k++) m_in[k] = $urandom;
      drive_in();
      IOBUS_ADDR = sa($urandom_range(0, P+2)); IOBUS_OUT = $urandom;
      IOBUS_WR = 1'($urandom); IRQ_SRC = N_IRQ'($urandom);
      tick();
      n_total++; if (OUT_DATA !== '0) $display("FAIL reset_out: got %h want 0", OUT_DATA); else n_pass++;
      n_total++; if (OUT_WSTB !== '0) $display("FAIL reset_wstb: got %b want 0", OUT_WSTB); else n_pass++;
      n_total++; if (INTR !== 1'b0) $display("FAIL reset_intr: got %b want 0", INTR); else n_pass++;
    end
    IOBUS_WR = 1'b0; IRQ_SRC = '0;
    rd(P+2, d);
    n_total++; if (d !== 32'hFFFFFFFF) $display("FAIL reset_cause: got %h want ffffffff", d); else n_pass++;
    rd(P, d);
    n_total++; if (d !== 32'h0) $display("FAIL reset_pend: got %h want 0", d); else n_pass++;
    for (int j = 0; j < N_OUT; j++) m_out[j] = '0;
    RESET_N = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_input_read();
    logic [31:0] d;
    int k;
    m_in[1] = 32'hA5A5_0001; drive_in();
    rd(1, d);
    n_total++; if (d !== 32'hA5A5_0001) $display("FAIL in_port1: got %h want a5a50001", d); else n_pass++;
    IOBUS_ADDR = sa(1) + 32'd4; #1;
    n_total++; if (IOBUS_IN !== 32'h0) $display("FAIL in_offset: got %h want 0", IOBUS_IN); else n_pass++;
    tick();
    for (int i = 0; i < 8; i++) begin
      for (int p = 0; p < N_IN; p++) m_in[p] = $urandom;
      drive_in();
      k = $urandom_range(0, N_IN-1);
      rd(k, d);
      n_total++; if (d !== m_in[k]) $display("FAIL in_rand%0d: got %h want %h", k, d, m_in[k]); else n_pass++;
      IOBUS_ADDR = sa($urandom_range(0, P+2)) + $urandom_range(1, int'(STRIDE) - 1); #1;
      n_total++; if (IOBUS_IN !== 32'h0) $display("FAIL unmapped: addr %h got %h want 0", IOBUS_ADDR, IOBUS_IN); else n_pass++;
      tick();
    end
    IOBUS_ADDR = BASE - 32'd4; #1;
    n_total++; if (IOBUS_IN !== 32'h0) $display("FAIL below_base: got %h want 0", IOBUS_IN); else n_pass++;
    tick();
  endtask

  task automatic test_output_write();
    logic [31:0] d;
    IOBUS_ADDR = sa(5); IOBUS_OUT = 32'h0000_BEEF; IOBUS_WR = 1'b1;
    tick();
    n_total++; if (OUT_DATA[63:32] !== 32'h0000_BEEF) $display("FAIL wr_beef: got %h want 0000beef", OUT_DATA[63:32]); else n_pass++;
    n_total++; if (OUT_WSTB !== 4'b0010) $display("FAIL wstb_1st: got %b want 0010", OUT_WSTB); else n_pass++;
    IOBUS_OUT = 32'h1;
    tick();
    n_total++; if (OUT_DATA[63:32] !== 32'h1) $display("FAIL wr_one: got %h want 1", OUT_DATA[63:32]); else n_pass++;
    n_total++; if (OUT_WSTB !== 4'b0010) $display("FAIL wstb_2nd: got %b want 0010", OUT_WSTB); else n_pass++;
    IOBUS_WR = 1'b0; IOBUS_ADDR = '0;
    m_out[1] = 32'h1;
    tick();
    n_total++; if (OUT_WSTB !== 4'b0000) $display("FAIL wstb_drop: got %b want 0000", OUT_WSTB); else n_pass++;
    n_total++; if (OUT_DATA !== exp_out()) $display("FAIL out_hold: got %h want %h", OUT_DATA, exp_out()); else n_pass++;
    rd(5, d);
    n_total++; if (d !== (RB ? 32'h1 : 32'h0)) $display("FAIL readback5: got %h want %h", d, RB ? 32'h1 : 32'h0); else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    int s;
    logic we;
    logic [N_OUT-1:0] ew;
    logic [31:0] dat, er;
    for (int i = 0; i < 24; i++) begin
      s = $urandom_range(0, P);
      dat = $urandom;
      we = 1'($urandom_range(0, 3) != 0);
      IOBUS_ADDR = (s == P) ? sa(P+3) : sa(s);
      IOBUS_OUT = dat; IOBUS_WR = we;
      ew = '0;
      if (we && s >= N_IN && s < P) begin
        m_out[s-N_IN] = dat;
        ew[s-N_IN] = 1'b1;
      end
      tick();
      n_total++; if (OUT_DATA !== exp_out()) $display("FAIL b2b_data%0d: got %h want %h", i, OUT_DATA, exp_out()); else n_pass++;
      n_total++; if (OUT_WSTB !== ew) $display("FAIL b2b_wstb%0d: got %b want %b", i, OUT_WSTB, ew); else n_pass++;
      if (s >= N_IN && s < P) begin
        er = RB ? m_out[s-N_IN] : 32'h0;
        n_total++; if (IOBUS_IN !== er) $display("FAIL b2b_read%0d: got %h want %h", i, IOBUS_IN, er); else n_pass++;
      end
    end
    IOBUS_WR = 1'b0; IOBUS_ADDR = '0;
    tick();
  endtask

  task automatic test_irq_flow();
    logic [31:0] d;
    wr(P+1, 32'hFFFFFFFF);
    rd(P+1, d);
    n_total++; if (d !== 32'h0000000F) $display("FAIL mask_width: got %h want 0000000f", d); else n_pass++;
    wr(P+1, 32'h4);
    IRQ_SRC = 4'b0101;
    tick(); tick();
    rd(P, d);
    n_total++; if (d !== 32'h0) $display("FAIL pend_edge2: got %h want 0", d); else n_pass++;
    tick();
    rd(P, d);
    n_total++; if (d !== 32'h5) $display("FAIL pend_edge3: got %h want 5", d); else n_pass++;
    n_total++; if (INTR !== 1'b0) $display("FAIL intr_edge3: got %b want 0", INTR); else n_pass++;
    tick();
    n_total++; if (INTR !== 1'b1) $display("FAIL intr_edge4: got %b want 1", INTR); else n_pass++;
    rd(P+2, d);
    n_total++; if (d !== 32'h2) $display("FAIL cause2: got %h want 2", d); else n_pass++;
    wr(P, 32'h4);
    rd(P, d);
    n_total++; if (d !== 32'h1) $display("FAIL pend_w1c: got %h want 1", d); else n_pass++;
    n_total++; if (INTR !== 1'b1) $display("FAIL intr_wr_edge: got %b want 1", INTR); else n_pass++;
    tick();
    n_total++; if (INTR !== 1'b0) $display("FAIL intr_cleared: got %b want 0", INTR); else n_pass++;
    rd(P+2, d);
    n_total++; if (d !== 32'hFFFFFFFF) $display("FAIL cause_none: got %h want ffffffff", d); else n_pass++;
    IRQ_SRC = '0;
    repeat (3) tick();
    wr(P, 32'hF);
    wr(P+1, 32'h0);
  endtask

  task automatic test_set_clear();
    logic [31:0] d;
    IRQ_SRC = 4'b1000;
    tick(); tick();
    IOBUS_ADDR = sa(P); IOBUS_OUT = 32'h8; IOBUS_WR = 1'b1;
    tick();
    IOBUS_WR = 1'b0;
    rd(P, d);
    n_total++; if (d !== 32'h8) $display("FAIL set_wins: got %h want 8", d); else n_pass++;
    wr(P, 32'h8);
    rd(P, d);
    n_total++; if (d !== 32'h0) $display("FAIL plain_clear: got %h want 0", d); else n_pass++;
    repeat (4) tick();
    rd(P, d);
    n_total++; if (d !== 32'h0) $display("FAIL held_high_once: got %h want 0", d); else n_pass++;
    IRQ_SRC = '0;
    tick(); tick();
    IRQ_SRC = 4'b1000;
    repeat (3) tick();
    rd(P, d);
    n_total++; if (d !== 32'h8) $display("FAIL rearm: got %h want 8", d); else n_pass++;
    IRQ_SRC = '0;
    repeat (3) tick();
    wr(P, 32'hF);
  endtask

  task automatic test_irq_random();
    logic [31:0] d;
    logic [N_IRQ-1:0] r, m;
    for (int i = 0; i < 6; i++) begin
      m = N_IRQ'($urandom);
      r = N_IRQ'($urandom_range(1, (1 << N_IRQ) - 1));
      wr(P+1, 32'(m));
      IRQ_SRC = r;
      repeat (3) tick();
      rd(P, d);
      n_total++; if (d !== 32'(r)) $display("FAIL rnd_pend%0d: got %h want %h", i, d, 32'(r)); else n_pass++;
      rd(P+2, d);
      n_total++; if (d !== exp_cause(r & m)) $display("FAIL rnd_cause%0d: got %h want %h", i, d, exp_cause(r & m)); else n_pass++;
      tick();
      n_total++; if (INTR !== |(r & m)) $display("FAIL rnd_intr%0d: got %b want %b", i, INTR, |(r & m)); else n_pass++;
      IRQ_SRC = '0;
      tick(); tick();
      wr(P, 32'hFFFFFFFF);
      rd(P, d);
      n_total++; if (d !== 32'h0) $display("FAIL rnd_clear%0d: got %h want 0", i, d); else n_pass++;
    end
    wr(P+1, 32'h0);
    tick();
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    m_out[0] = $urandom | 32'h1;
    wr(N_IN, m_out[0]);
    IRQ_SRC = 4'b0010;
    repeat (3) tick();
    wr(P+1, 32'h2);
    tick();
    n_total++; if (INTR !== 1'b1) $display("FAIL pre_reset_intr: got %b want 1", INTR); else n_pass++;
    #2 RESET_N = 1'b0;
    #1;
    for (int j = 0; j < N_OUT; j++) m_out[j] = '0;
    n_total++; if (OUT_DATA !== exp_out()) $display("FAIL mid_out: got %h want %h", OUT_DATA, exp_out()); else n_pass++;
    n_total++; if (INTR !== 1'b0) $display("FAIL mid_intr: got %b want 0", INTR); else n_pass++;
    rd(P, d);
    n_total++; if (d !== 32'h0) $display("FAIL mid_pend: got %h want 0", d); else n_pass++;
    rd(P+1, d);
    n_total++; if (d !== 32'h0) $display("FAIL mid_mask: got %h want 0", d); else n_pass++;
    tick(); tick();
    RESET_N = 1'b1;
    tick(); tick();
    rd(P, d);
    n_total++; if (d !== 32'h0) $display("FAIL post_rel_edge2: got %h want 0", d); else n_pass++;
    tick();
    rd(P, d);
    n_total++; if (d !== 32'h2) $display("FAIL post_rel_edge3: got %h want 2", d); else n_pass++;
    IRQ_SRC = '0;
    tick();
  endtask

  initial begin
    for (int j = 0; j < N_OUT; j++) m_out[j] = '0;
    for (int k = 0; k < N_IN; k++) m_in[k] = '0;
    test_reset();
    test_input_read();
    test_output_write();
    test_back_to_back();
    test_irq_flow();
    test_set_clear();
    test_irq_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mmio_hub.md
# mmio_hub

Parametrised memory-mapped I/O hub between the OTTER MCU I/O bus and board peripherals. It replaces a fixed address-decode wrapper with several additions:
- N input ports and M output registers on a regular base-plus-stride address map.
- A one-cycle write strobe per output register, for peripherals such as the VGA write-enable and the UART start.
- A built-in interrupt controller with synchronised edge-triggered sources, pending, mask and cause registers, driving the MCU INTR pin.

## Interface
Parameters:
- N_IN, 4: number of 32-bit input ports (1..16).
- N_OUT, 4: number of 32-bit output registers (1..16).
- N_IRQ, 4: number of interrupt sources (1..32).
- BASE, 32'h11000000: address of slot 0.
- STRIDE, 32'h00040000: address distance between slots.

Ports:
- CLK  in  1  system clock; all state on rising edge.
- RESET_N  in  1  reset; asynchronous, active-low.
- IOBUS_ADDR  in  32  MCU I/O address.
- IOBUS_OUT  in  32  MCU write data.
- IOBUS_WR  in  1  MCU write enable.
- IOBUS_IN  out  32  read data to MCU; combinational from IOBUS_ADDR.
- IN_DATA  in  32*N_IN  input ports; port k is IN_DATA[32k+31:32k].
- OUT_DATA  out  32*N_OUT  output registers; packed the same way.
- OUT_WSTB  out  N_OUT  one-cycle pulse per output register write.
- IRQ_SRC  in  N_IRQ  asynchronous interrupt request levels.
- INTR  out  1  registered interrupt request to the MCU.

## Operation
- Slot k sits at address BASE + k*STRIDE. Only exact matches decode.
- Address map:
  - Slots 0..N_IN-1: input ports, read-only.
  - Slots N_IN..N_IN+N_OUT-1: output registers.
  - Slot P = N_IN+N_OUT: IRQ_PEND.
  - Slot P+1: IRQ_MASK.
  - Slot P+2: IRQ_CAUSE.
- Unmapped addresses: read 32'h0; writes ignored.
- Input slot read returns IN_DATA port, unregistered.
- Output register write (IOBUS_WR=1 at that slot): register loads IOBUS_OUT; matching OUT_WSTB bit asserted.
- Interrupt path:
  - Each IRQ_SRC bit passes a two-flop synchroniser, then rising-edge detect against a third flop.
  - A detected edge sets IRQ_PEND[i].
- IRQ_PEND:
  - Read returns pending bits, zero-extended.
  - Write clears each bit where IOBUS_OUT is 1 (write-1-to-clear).
  - Set and clear of the same bit in the same cycle: set wins, bit stays 1.
- IRQ_MASK: read/write; only bits [N_IRQ-1:0] are stored, upper bits read 0. A 1 enables the source.
- IRQ_CAUSE: read-only. Returns the index of the lowest set bit of IRQ_PEND & IRQ_MASK, or 32'hFFFFFFFF if none.
- INTR register: loads |(IRQ_PEND & IRQ_MASK) every cycle.
- Reset (asynchronous, RESET_N=0) clears OUT_DATA, OUT_WSTB, IRQ_PEND, IRQ_MASK, all synchroniser and edge flops, and INTR.
- Reset mid-operation: in-flight edges and pending bits are discarded.
- A source still high when RESET_N releases registers as a new rising edge.

## Timing
- Read latency 0: IOBUS_IN settles in the same cycle as IOBUS_ADDR.
- Output write: OUT_DATA and OUT_WSTB change at the edge that samples IOBUS_WR=1. OUT_WSTB is high for exactly that one cycle.
- Back-to-back writes to the same slot hold OUT_WSTB high for every written cycle; each cycle loads new data.
- IRQ latency: with IRQ_SRC rising before edge 1, IRQ_PEND is set at edge 3 and INTR (if masked in) rises at edge 4.
- Mask/pend write to INTR: INTR reflects the new state one edge after the write edge.
- Source pulses shorter than one CLK period are not guaranteed to be captured.
- A source held high produces a single pending set. Re-arming requires a low period of at least 2 cycles.

## Configuration
- MMIO_HUB_READBACK_EN defined: reading an output slot returns the current OUT_DATA register.
- MMIO_HUB_READBACK_EN undefined: output slots read 32'h0 (write-only), and the readback mux is not built.
- Writes and all other behaviour are identical in both builds.

## Test plan
- Reset values: hold RESET_N=0 with all inputs toggling -> OUT_DATA=0, OUT_WSTB=0, INTR=0. Reading IRQ_CAUSE returns 32'hFFFFFFFF.
- Input read and decode:
  - Drive IN_DATA port 1 = 32'hA5A5_0001 and read BASE+STRIDE -> IOBUS_IN=32'hA5A5_0001.
  - Read BASE+STRIDE+4 -> 32'h0.
- Output write and strobe: with defaults, write 32'h0000_BEEF to slot 5, then 32'h1 to slot 5 on the next cycle.
  - Expected: OUT_DATA port 1 = BEEF then 1; OUT_WSTB[1] high two cycles; other strobes stay 0.
  - Readback of slot 5 gives 1 with MMIO_HUB_READBACK_EN, 0 without.
- IRQ flow:
  - Write IRQ_MASK=4'b0100, then raise IRQ_SRC[2] and IRQ_SRC[0].
  - Expected: IRQ_PEND=4'b0101 at edge 3, INTR=1 at edge 4, IRQ_CAUSE=2.
  - Write IRQ_PEND=4'b0100 -> INTR=0 one edge later; IRQ_PEND=4'b0001.
- Simultaneous set/clear: a new IRQ_SRC[3] edge lands in the same cycle as a write-1-to-clear of bit 3 -> IRQ_PEND[3] remains 1.
- Reset mid-operation: assert RESET_N=0 while IRQ_PEND is nonzero and IRQ_SRC[1] is held high, then release.
  - Expected: state cleared immediately; IRQ_PEND[1] sets 3 edges after release.
